// File: rtl/sm_mavg.sv
// Moving-average smoothing stage for raw ADC samples.
// Keeps a circular history of the last 2^LOG2_MAX samples and a running sum
// over the active window of N = 2^cfg_win samples. An average is emitted only
// once the window holds N real samples, so after reset, a flush or a window
// change no partial-window average ever reaches the parameter stage.
module sm_mavg #(
    parameter int LOG2_MAX = 4,
    parameter int DW       = 16
) (
    input  logic                clk_sys,
    input  logic                rst,
    input  logic [DW-1:0]       adc_data,
    input  logic                adc_vld,
    input  logic [2:0]          cfg_win,
    input  logic                cfg_clr,
    output logic [DW-1:0]       sm_data,
    output logic                sm_vld,
    output logic [LOG2_MAX:0]   sta_fill
);

    localparam int DEPTH = 1 << LOG2_MAX;
    localparam int ACC_W = DW + LOG2_MAX;
    localparam int FW    = LOG2_MAX + 1;
    localparam logic [2:0] MAX_WIN = 3'(LOG2_MAX);

    logic [DW-1:0]       hist [DEPTH];
    logic [LOG2_MAX-1:0] wr_ptr;
    logic [LOG2_MAX-1:0] rd_ptr;
    logic [2:0]          win_q;
    logic [2:0]          win_new;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_base;
    logic [ACC_W-1:0]    acc_next;
    logic [FW-1:0]       fill_base;
    logic [FW-1:0]       fill_next;
    logic [FW-1:0]       n_val;
    logic [DW-1:0]       old;
    logic [DW-1:0]       avg_next;
    logic                restart;
    logic                full;
    logic                emit;

    // Clamp the requested window, find the outgoing sample and decide whether
    // this cycle starts a fresh warm-up (flush or new window size).
    always_comb begin
        win_new = (cfg_win > MAX_WIN) ? MAX_WIN : cfg_win;
        n_val   = FW'(1) << win_new;
        // For the maximum window the low bits of N are zero, so the read
        // pointer lands on the slot about to be overwritten, which is exactly
        // the sample leaving the window.
        rd_ptr  = wr_ptr - n_val[LOG2_MAX-1:0];
        old     = hist[rd_ptr];
        restart = cfg_clr || (win_new != win_q);
    end

    // Running-sum update; a restart zeroes the sum first so a sample arriving
    // in the same cycle becomes the first sample of the new window.
    always_comb begin
        acc_base  = restart ? '0 : acc;
        fill_base = restart ? '0 : sta_fill;
        full      = (fill_base == n_val);
        acc_next  = acc_base;
        fill_next = fill_base;
        if (adc_vld) begin
            if (full) begin
                acc_next = acc_base + ACC_W'(adc_data) - ACC_W'(old);
            end else begin
                acc_next  = acc_base + ACC_W'(adc_data);
                fill_next = fill_base + FW'(1);
            end
        end
        emit     = adc_vld && (fill_next == n_val);
        avg_next = DW'(acc_next >> win_new);
    end

    // History buffer; stale contents are never used because the fill count
    // keeps the sum from subtracting anything until the window is full.
    always_ff @(posedge clk_sys) begin
        if (adc_vld) begin
            hist[wr_ptr] <= adc_data;
        end
    end

    // Sum, fill count, write pointer, latched window and registered outputs.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            sta_fill <= '0;
            wr_ptr   <= '0;
            win_q    <= '0;
            sm_data  <= '0;
            sm_vld   <= 1'b0;
        end else begin
            win_q    <= win_new;
            acc      <= acc_next;
            sta_fill <= fill_next;
            sm_vld   <= emit;
            if (adc_vld) begin
                wr_ptr <= wr_ptr + LOG2_MAX'(1);
            end
            if (emit) begin
                sm_data <= avg_next;
            end
        end
    end

endmodule

// File: tb/tb_sm_mavg.sv
// Directed self-checking bench for the moving-average smoothing stage.
module tb_sm_mavg;

    logic        clk_sys;
    logic        rst;
    logic [15:0] adc_data;
    logic        adc_vld;
    logic [2:0]  cfg_win;
    logic        cfg_clr;
    logic [15:0] sm_data;
    logic        sm_vld;
    logic [4:0]  sta_fill;

    int errors;
    int checks;

    sm_mavg #(.LOG2_MAX(4), .DW(16)) dut (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .adc_data (adc_data),
        .adc_vld  (adc_vld),
        .cfg_win  (cfg_win),
        .cfg_clr  (cfg_clr),
        .sm_data  (sm_data),
        .sm_vld   (sm_vld),
        .sta_fill (sta_fill)
    );

    // Free-running 10 ns system clock.
    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Drive one cycle of input, then sample just after the rising edge.
    task automatic applyStimulus(input logic vld, input logic [15:0] data);
        adc_vld  = vld;
        adc_data = data;
        @(posedge clk_sys);
        #1;
        adc_vld = 1'b0;
        cfg_clr = 1'b0;
    endtask

    // Compare outputs against hand-computed values; data only when requested.
    task automatic checkOutput(input string tag, input logic exp_vld,
                               input logic [15:0] exp_data, input logic [4:0] exp_fill,
                               input bit chk_data);
        checks++;
        assert (sm_vld === exp_vld) else begin
            errors++;
            $error("[TB] FAIL %s sm_vld observed=%0b expected=%0b", tag, sm_vld, exp_vld);
        end
        checks++;
        assert (sta_fill === exp_fill) else begin
            errors++;
            $error("[TB] FAIL %s sta_fill observed=%0d expected=%0d", tag, sta_fill, exp_fill);
        end
        if (chk_data) begin
            checks++;
            assert (sm_data === exp_data) else begin
                errors++;
                $error("[TB] FAIL %s sm_data observed=0x%04h expected=0x%04h", tag, sm_data, exp_data);
            end
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        adc_data = '0;
        adc_vld  = 1'b0;
        cfg_win  = 3'd2;
        cfg_clr  = 1'b0;
        #1;
        checkOutput("reset", 1'b0, 16'h0000, 5'd0, 1'b1);
        @(negedge clk_sys);
        rst = 1'b0;

        // Window of 4: ramp input, first average after the fourth sample.
        applyStimulus(1'b1, 16'd4);   checkOutput("w4_s1", 1'b0, 16'd0, 5'd1, 1'b0);
        applyStimulus(1'b1, 16'd8);   checkOutput("w4_s2", 1'b0, 16'd0, 5'd2, 1'b0);
        applyStimulus(1'b1, 16'd12);  checkOutput("w4_s3", 1'b0, 16'd0, 5'd3, 1'b0);
        applyStimulus(1'b1, 16'd16);  checkOutput("w4_s4", 1'b1, 16'd10, 5'd4, 1'b1);
        applyStimulus(1'b1, 16'd20);  checkOutput("w4_s5", 1'b1, 16'd14, 5'd4, 1'b1);
        applyStimulus(1'b0, 16'd0);   checkOutput("w4_hold", 1'b0, 16'd14, 5'd4, 1'b1);

        // Window of 1: pass-through with gaps.
        cfg_win = 3'd0;
        applyStimulus(1'b0, 16'd0);      checkOutput("w1_switch", 1'b0, 16'd14, 5'd0, 1'b1);
        applyStimulus(1'b1, 16'h1234);   checkOutput("w1_a", 1'b1, 16'h1234, 5'd1, 1'b1);
        applyStimulus(1'b0, 16'd0);      checkOutput("w1_gap1", 1'b0, 16'h1234, 5'd1, 1'b1);
        applyStimulus(1'b0, 16'd0);      checkOutput("w1_gap2", 1'b0, 16'h1234, 5'd1, 1'b1);
        applyStimulus(1'b1, 16'hFFFF);   checkOutput("w1_b", 1'b1, 16'hFFFF, 5'd1, 1'b1);
        applyStimulus(1'b0, 16'd0);      checkOutput("w1_gap3", 1'b0, 16'hFFFF, 5'd1, 1'b1);

        // Window of 2: truncating average.
        cfg_win = 3'd1;
        applyStimulus(1'b0, 16'd0);   checkOutput("w2_switch", 1'b0, 16'd0, 5'd0, 1'b0);
        applyStimulus(1'b1, 16'd1);   checkOutput("w2_s1", 1'b0, 16'd0, 5'd1, 1'b0);
        applyStimulus(1'b1, 16'd2);   checkOutput("w2_s2", 1'b1, 16'd1, 5'd2, 1'b1);
        applyStimulus(1'b1, 16'd2);   checkOutput("w2_s3", 1'b1, 16'd2, 5'd2, 1'b1);
        applyStimulus(1'b1, 16'd3);   checkOutput("w2_s4", 1'b1, 16'd2, 5'd2, 1'b1);

        // Window of 4 for six samples, then switch to 2 mid-stream.
        cfg_win = 3'd2;
        applyStimulus(1'b0, 16'd0);   checkOutput("sw_to4", 1'b0, 16'd0, 5'd0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 16'(10 * i));
        end
        checkOutput("sw_w4_last", 1'b1, 16'd45, 5'd4, 1'b1);
        cfg_win = 3'd1;
        applyStimulus(1'b0, 16'd0);   checkOutput("sw_to2", 1'b0, 16'd45, 5'd0, 1'b1);
        applyStimulus(1'b1, 16'd100); checkOutput("sw_100", 1'b0, 16'd45, 5'd1, 1'b1);
        applyStimulus(1'b1, 16'd200); checkOutput("sw_200", 1'b1, 16'd150, 5'd2, 1'b1);

        // Asynchronous reset while the sum is nonzero and sm_vld is high.
        applyStimulus(1'b1, 16'd6);   checkOutput("pre_rst_a", 1'b1, 16'd103, 5'd2, 1'b1);
        applyStimulus(1'b1, 16'd8);   checkOutput("pre_rst_b", 1'b1, 16'd7, 5'd2, 1'b1);
        #2 rst = 1'b1;
        #1 checkOutput("async_rst", 1'b0, 16'd0, 5'd0, 1'b1);
        @(negedge clk_sys);
        rst = 1'b0;
        applyStimulus(1'b1, 16'd4);   checkOutput("post_rst_s1", 1'b0, 16'd0, 5'd1, 1'b1);
        applyStimulus(1'b1, 16'd6);   checkOutput("post_rst_s2", 1'b1, 16'd5, 5'd2, 1'b1);

        // cfg_win above the maximum clamps to a 16-sample window.
        cfg_win = 3'd7;
        applyStimulus(1'b0, 16'd0);   checkOutput("w16_switch", 1'b0, 16'd5, 5'd0, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 16'hFFFF);
            checkOutput($sformatf("w16_ones_%0d", i), (i == 16), 16'hFFFF, 5'(i), (i == 16));
        end
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b1, 16'h0000);
            checkOutput($sformatf("w16_zeros_%0d", k), 1'b1, 16'(((16 - k) * 65535) >> 4), 5'd16, 1'b1);
        end

        // Flush coinciding with a sample: that sample starts the new warm-up.
        cfg_clr = 1'b1;
        applyStimulus(1'b1, 16'h0010); checkOutput("clr_with_vld", 1'b0, 16'h0000, 5'd1, 1'b1);
        applyStimulus(1'b1, 16'h0020); checkOutput("clr_next", 1'b0, 16'h0000, 5'd2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
